stopwatch_time_counter: RTL and testbench

//  Time-base datapath with run/stop/clear control. Produces the msec/sec/min/hour

---
 rtl/stopwatch_time_counter.sv | 161 ++++++++++++++++
 tb/tb_stopwatch_time_counter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_time_counter.sv
// Stopwatch time base: a clock divider feeds a cascaded msec/sec/min/hour chain.
// A STOP/RUN/CLEAR FSM gates counting, and the *_up pulses set the time while stopped.
module stopwatch_time_counter #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int TICK_HZ  = 100,
   parameter int MSEC_MAX = 100,
   parameter int SEC_MAX  = 60,
   parameter int MIN_MAX  = 60,
   parameter int HOUR_MAX = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_run_stop,
   input  logic       i_clear,
   input  logic       i_sec_up,
   input  logic       i_min_up,
   input  logic       i_hour_up,
   output logic [6:0] msec,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic [4:0] hour,
   output logic       o_running,
   output logic       o_tick
);

   localparam int DIV   = CLK_FREQ / TICK_HZ;
   localparam int DIV_W = $clog2(DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             running_q;
   logic             tick_q;
   logic             tick_en;
   logic             set_en;
   logic             clear_en;
   logic [2:0]       field_wrap;
   logic [2:0]       up_pulse;

   assign up_pulse = {i_hour_up, i_min_up, i_sec_up};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_STOP;
      end else begin
         state_q <= state_d;
      end
   end

   // Clear beats run/stop when both arrive in STOP.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_STOP: begin
            if (i_clear) begin
               state_d = ST_CLEAR;
            end else if (i_run_stop) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (i_run_stop) begin
               state_d = ST_STOP;
            end
         end
         ST_CLEAR: state_d = ST_STOP;
         default:  state_d = ST_STOP;
      endcase
   end

   always_comb begin
      tick_en  = 1'b0;
      set_en   = 1'b0;
      clear_en = 1'b0;
      case (state_q)
         ST_STOP:  set_en   = ~i_clear;
         ST_RUN:   tick_en  = (div_q == DIV_LAST);
         ST_CLEAR: clear_en = 1'b1;
         default:  ;
      endcase
   end

   // Divider holds in STOP so the sub-tick phase survives a pause.
   always_comb begin
      div_d = div_q;
      if (clear_en) begin
         div_d = '0;
      end else if (state_q == ST_RUN) begin
         div_d = tick_en ? '0 : div_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q     <= '0;
         running_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         div_q     <= div_d;
         running_q <= (state_d == ST_RUN);
         tick_q    <= tick_en;
      end
   end

   assign o_running = running_q;
   assign o_tick    = tick_q;

   // Field 0..3 = msec, sec, min, hour; carries ripple combinationally in one edge.
   for (genvar gi = 0; gi < 4; gi++) begin : g_field
      localparam int FW   = (gi == 0) ? 7 : ((gi == 3) ? 5 : 6);
      localparam int FMAX = (gi == 0) ? MSEC_MAX :
                            (gi == 1) ? SEC_MAX  :
                            (gi == 2) ? MIN_MAX  : HOUR_MAX;
      localparam logic [FW-1:0] LAST = FW'(FMAX - 1);

      logic [FW-1:0] value_q, value_d;
      logic          wrap;
      logic          inc;

      assign wrap = (value_q == LAST);

      if (gi == 0) begin : g_inc_tick
         assign inc = tick_en;
      end else begin : g_inc_chain
         assign inc = (tick_en & (&field_wrap[gi-1:0])) | (set_en & up_pulse[gi-1]);
      end

      if (gi < 3) begin : g_wrap_out
         assign field_wrap[gi] = wrap;
      end

      always_comb begin
         value_d = value_q;
         if (clear_en) begin
            value_d = '0;
         end else if (inc) begin
            value_d = wrap ? '0 : value_q + 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            value_q <= '0;
         end else begin
            value_q <= value_d;
         end
      end
   end

   assign msec = g_field[0].value_q;
   assign sec  = g_field[1].value_q;
   assign min  = g_field[2].value_q;
   assign hour = g_field[3].value_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: per-cycle scoreboard against a total-time model,
// a table of pulse/checkpoint vectors, and hand sequences for tick timing corners.
module tb_stopwatch_time_counter;

   localparam int CLK_FREQ = 1000;
   localparam int TICK_HZ  = 100;
   localparam int DIV      = CLK_FREQ / TICK_HZ;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       i_run_stop = 1'b0;
   logic       i_clear = 1'b0;
   logic       i_sec_up = 1'b0;
   logic       i_min_up = 1'b0;
   logic       i_hour_up = 1'b0;
   logic [6:0] msec;
   logic [5:0] sec;
   logic [5:0] min;
   logic [4:0] hour;
   logic       o_running;
   logic       o_tick;

   always #5 clk = ~clk;

   stopwatch_time_counter #(
      .CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ),
      .MSEC_MAX(100), .SEC_MAX(60), .MIN_MAX(60), .HOUR_MAX(24)
   ) dut (
      .clk(clk), .reset(reset), .i_run_stop(i_run_stop), .i_clear(i_clear),
      .i_sec_up(i_sec_up), .i_min_up(i_min_up), .i_hour_up(i_hour_up),
      .msec(msec), .sec(sec), .min(min), .hour(hour),
      .o_running(o_running), .o_tick(o_tick)
   );

   typedef struct {
      int ms; int s; int m; int h; bit run; bit tick;
   } exp_t;

   typedef struct {
      bit rst; bit rs; bit clr; bit su; bit mu; bit hu;
      int reps; int idle;
      int e_ms; int e_s; int e_m; int e_h; bit e_run; bit e_tick;
   } vec_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   // Model state: 0=STOP 1=RUN 2=CLEAR
   int m_st = 0, m_div = 0, m_ms = 0, m_s = 0, m_m = 0, m_h = 0;
   bit m_run = 1'b0, m_tick = 1'b0;

   task automatic model_step(input bit rst, input bit rs, input bit clr,
                             input bit su, input bit mu, input bit hu);
      int total;
      if (rst) begin
         m_st = 0; m_div = 0; m_ms = 0; m_s = 0; m_m = 0; m_h = 0; m_tick = 1'b0;
      end else begin
         m_tick = 1'b0;
         case (m_st)
            0: begin
               if (clr) m_st = 2;
               else begin
                  if (su) m_s = (m_s + 1) % 60;
                  if (mu) m_m = (m_m + 1) % 60;
                  if (hu) m_h = (m_h + 1) % 24;
                  if (rs) m_st = 1;
               end
            end
            1: begin
               if (m_div == DIV - 1) begin
                  m_div  = 0;
                  m_tick = 1'b1;
                  total  = (((m_h * 60 + m_m) * 60 + m_s) * 100 + m_ms + 1) % (24 * 3600 * 100);
                  m_ms   = total % 100;
                  m_s    = (total / 100) % 60;
                  m_m    = (total / 6000) % 60;
                  m_h    = total / 360000;
               end else begin
                  m_div = m_div + 1;
               end
               if (rs) m_st = 0;
            end
            default: begin
               m_st = 0; m_div = 0; m_ms = 0; m_s = 0; m_m = 0; m_h = 0;
            end
         endcase
      end
      m_run = (m_st == 1);
   endtask

   task automatic cycle(input bit rst, input bit rs, input bit clr,
                        input bit su, input bit mu, input bit hu);
      exp_t e;
      reset = rst; i_run_stop = rs; i_clear = clr;
      i_sec_up = su; i_min_up = mu; i_hour_up = hu;
      model_step(rst, rs, clr, su, mu, hu);
      e.ms = m_ms; e.s = m_s; e.m = m_m; e.h = m_h; e.run = m_run; e.tick = m_tick;
      sb.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      reset = 1'b0; i_run_stop = 1'b0; i_clear = 1'b0;
      i_sec_up = 1'b0; i_min_up = 1'b0; i_hour_up = 1'b0;
      e = sb.pop_front();
      n_checks++;
      if (int'(msec) == e.ms && int'(sec) == e.s && int'(min) == e.m && int'(hour) == e.h &&
          o_running == e.run && o_tick == e.tick) begin
         n_pass++;
      end else begin
         $display("FAIL scoreboard cyc=%0d got %0d:%0d:%0d.%0d run=%0b tick=%0b expected %0d:%0d:%0d.%0d run=%0b tick=%0b",
                  cyc, hour, min, sec, msec, o_running, o_tick, e.h, e.m, e.s, e.ms, e.run, e.tick);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check(input string name, input int got, input int want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s got=%0d expected=%0d", name, got, want);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout at cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vt[18];
      int   prev;
      int   ticks;
      int   gap;
      bit   found;

      //         rst rs clr su mu hu reps idle ms  s  m  h run tick
      vt[0]  = '{1, 0, 0, 0, 0, 0,  1, 0,  0,  0, 0, 0, 0, 0};
      vt[1]  = '{0, 0, 0, 1, 0, 0,  1, 0,  0,  1, 0, 0, 0, 0};
      vt[2]  = '{0, 0, 0, 0, 1, 1,  1, 0,  0,  1, 1, 1, 0, 0};
      vt[3]  = '{0, 0, 0, 1, 1, 1,  1, 0,  0,  2, 2, 2, 0, 0};
      vt[4]  = '{0, 0, 1, 1, 0, 0,  1, 0,  0,  2, 2, 2, 0, 0};
      vt[5]  = '{0, 0, 0, 0, 0, 0,  0, 1,  0,  0, 0, 0, 0, 0};
      vt[6]  = '{0, 1, 0, 1, 0, 0,  1, 0,  0,  1, 0, 0, 1, 0};
      vt[7]  = '{0, 0, 1, 0, 0, 0,  1, 0,  0,  1, 0, 0, 1, 0};
      vt[8]  = '{0, 0, 0, 1, 1, 1,  1, 0,  0,  1, 0, 0, 1, 0};
      vt[9]  = '{0, 0, 0, 0, 0, 0,  0, 8,  1,  1, 0, 0, 1, 1};
      vt[10] = '{0, 1, 0, 0, 0, 0,  1, 0,  1,  1, 0, 0, 0, 0};
      vt[11] = '{0, 1, 1, 0, 0, 0,  1, 0,  1,  1, 0, 0, 0, 0};
      vt[12] = '{0, 0, 0, 0, 0, 0,  0, 1,  0,  0, 0, 0, 0, 0};
      vt[13] = '{0, 0, 0, 1, 0, 0, 59, 0,  0, 59, 0, 0, 0, 0};
      vt[14] = '{0, 0, 0, 1, 0, 0,  1, 0,  0,  0, 0, 0, 0, 0};
      vt[15] = '{0, 0, 0, 0, 1, 1,  1, 0,  0,  0, 1, 1, 0, 0};
      vt[16] = '{0, 0, 0, 0, 0, 1, 23, 0,  0,  0, 1, 0, 0, 0};
      vt[17] = '{0, 0, 0, 0, 1, 0, 59, 0,  0,  0, 0, 0, 0, 0};

      for (int i = 0; i < 18; i++) begin
         repeat (vt[i].reps) cycle(vt[i].rst, vt[i].rs, vt[i].clr, vt[i].su, vt[i].mu, vt[i].hu);
         idle(vt[i].idle);
         check($sformatf("vec%0d_msec", i), int'(msec), vt[i].e_ms);
         check($sformatf("vec%0d_sec", i), int'(sec), vt[i].e_s);
         check($sformatf("vec%0d_min", i), int'(min), vt[i].e_m);
         check($sformatf("vec%0d_hour", i), int'(hour), vt[i].e_h);
         check($sformatf("vec%0d_running", i), int'(o_running), int'(vt[i].e_run));
         check($sformatf("vec%0d_tick", i), int'(o_tick), int'(vt[i].e_tick));
      end

      // 1000 cycles of RUN: 100 ticks, evenly spaced
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      prev  = cyc;
      ticks = 0;
      for (int i = 0; i < 1000; i++) begin
         idle(1);
         if (o_tick) begin
            ticks++;
            check("run_tick_spacing", cyc - prev, DIV);
            prev = cyc;
         end
      end
      check("run_tick_count", ticks, 100);
      check("run_msec", int'(msec), 0);
      check("run_sec", int'(sec), 1);

      // 23:59:59.99 rolls to 00:00:00.00 on one tick
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (23) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (59) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (59) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("set_hour", int'(hour), 23);
      check("set_min", int'(min), 59);
      check("set_sec", int'(sec), 59);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(990);
      check("preload_msec", int'(msec), 99);
      check("preload_sec", int'(sec), 59);
      idle(9);
      check("pre_roll_msec", int'(msec), 99);
      idle(1);
      check("roll_tick", int'(o_tick), 1);
      check("roll_value", ((int'(hour) * 60 + int'(min)) * 60 + int'(sec)) * 100 + int'(msec), 0);

      // Pause keeps divider phase; resume ticks after the remaining 5 cycles
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(24);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("pause_msec", int'(msec), 2);
      ticks = 0;
      for (int i = 0; i < 100; i++) begin
         idle(1);
         if (o_tick) ticks++;
      end
      check("pause_ticks", ticks, 0);
      check("pause_msec_frozen", int'(msec), 2);
      check("pause_running", int'(o_running), 0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      gap   = 0;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         idle(1);
         gap++;
         if (o_tick) found = 1'b1;
      end
      check("resume_tick_gap", found ? gap : -1, 5);

      // Reset mid-RUN at 00:00:05.37 restores divider phase too
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(5370);
      check("midrun_msec", int'(msec), 37);
      check("midrun_sec", int'(sec), 5);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("midreset_value", int'(msec) + int'(sec) + int'(min) + int'(hour), 0);
      check("midreset_running", int'(o_running), 0);
      check("midreset_tick", int'(o_tick), 0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      gap   = 0;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         idle(1);
         gap++;
         if (o_tick) found = 1'b1;
      end
      check("post_reset_first_tick", found ? gap : -1, DIV);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
